// File: rtl/cl_sda_mstr_pkg.sv
// Shared definitions for the command-to-AXI-Lite master cl_sda_mstr.
//   state_t            : controller states
//   RESP_*             : AXI response codes
//   TIMEOUT_CYCLES_DEF : default transaction timeout in clock cycles
package cl_sda_mstr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP,
    DRAIN
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/axi_bus_t.sv
// AXI-Lite bus bundle (32-bit address and data).
//   modport slave  : the initiator-side view (drives AW/W/AR and B/R readies);
//                    it is the modport cl_sda_mstr plugs into.
//   modport target : the responder-side view.
interface axi_bus_t;

  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport target (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/cl_sda_mstr.sv
// Single-outstanding command to AXI-Lite master with timeout and error count.
//   aclk, aresetn            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      : command handshake (ready only while idle)
//   cmd_wr/addr/wdata/wstrb  : command fields (wdata/wstrb ignored on reads)
//   rsp_valid/rsp_ready      : completion handshake
//   rsp_rdata/resp/timeout   : completion fields
//   m_axil                   : AXI-Lite initiator port
//   err_cnt                  : saturating count of error/timeout completions
module cl_sda_mstr
  import cl_sda_mstr_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned ERR_CNT_W      = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wr,
  input  logic [31:0]          cmd_addr,
  input  logic [31:0]          cmd_wdata,
  input  logic [3:0]           cmd_wstrb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic [1:0]           rsp_resp,
  output logic                 rsp_timeout,
  axi_bus_t.slave              m_axil,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          is_wr;
  logic          awvalid_q, wvalid_q, arvalid_q;
  logic          bready_q, rready_q;
  logic          resp_pend;   // B or R response of this transaction not yet taken
  logic [TW-1:0] tcnt;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic aw_left, w_left, ar_left, resp_left;
  logic busy_after, expired;

  assign m_axil.awaddr  = addr_q;
  assign m_axil.awprot  = '0;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = wstrb_q;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.araddr  = addr_q;
  assign m_axil.arprot  = '0;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;

  always_comb begin
    aw_hs = awvalid_q & m_axil.awready;
    w_hs  = wvalid_q  & m_axil.wready;
    ar_hs = arvalid_q & m_axil.arready;
    b_hs  = bready_q  & m_axil.bvalid;
    r_hs  = rready_q  & m_axil.rvalid;
    // What is still owed to/by the slave after this cycle's edge
    aw_left    = awvalid_q & ~m_axil.awready;
    w_left     = wvalid_q  & ~m_axil.wready;
    ar_left    = arvalid_q & ~m_axil.arready;
    resp_left  = resp_pend & ~(b_hs | r_hs);
    busy_after = aw_left | w_left | ar_left | resp_left;
    expired    = (tcnt == T_LAST);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      is_wr       <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      resp_pend   <= 1'b0;
      tcnt        <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_timeout <= 1'b0;
      err_cnt     <= '0;
    end else begin
      if (state inside {WR, WR_RESP, RD_ADDR, RD_DATA})
        tcnt <= tcnt + 1'b1;

      // Valids drop the cycle after their own handshake in every state,
      // so a timeout never disturbs a pending AXI request.
      if (aw_hs) awvalid_q <= 1'b0;
      if (w_hs)  wvalid_q  <= 1'b0;
      if (ar_hs) arvalid_q <= 1'b0;
      if (b_hs | r_hs) resp_pend <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            is_wr     <= cmd_wr;
            tcnt      <= '0;
            resp_pend <= 1'b1;
            if (cmd_wr) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WR;
            end else begin
              arvalid_q <= 1'b1;
              state     <= RD_ADDR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        WR: begin
          if (expired) begin
            state       <= RSP;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_resp    <= RESP_SLVERR;
            rsp_rdata   <= '0;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end else if (!aw_left && !w_left) begin
            state    <= WR_RESP;
            bready_q <= 1'b1;
          end
        end

        WR_RESP: begin
          // A response in the expiry cycle takes precedence over the timeout
          if (b_hs) begin
            state       <= RSP;
            bready_q    <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b0;
            rsp_resp    <= m_axil.bresp;
            rsp_rdata   <= '0;
            if (m_axil.bresp != RESP_OKAY && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end else if (expired) begin
            state       <= RSP;
            bready_q    <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_resp    <= RESP_SLVERR;
            rsp_rdata   <= '0;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end
        end

        RD_ADDR: begin
          if (expired) begin
            state       <= RSP;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_resp    <= RESP_SLVERR;
            rsp_rdata   <= '0;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end else if (ar_hs) begin
            state    <= RD_DATA;
            rready_q <= 1'b1;
          end
        end

        RD_DATA: begin
          if (r_hs) begin
            state       <= RSP;
            rready_q    <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b0;
            rsp_resp    <= m_axil.rresp;
            rsp_rdata   <= m_axil.rdata;
            if (m_axil.rresp != RESP_OKAY && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end else if (expired) begin
            state       <= RSP;
            rready_q    <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_resp    <= RESP_SLVERR;
            rsp_rdata   <= '0;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (busy_after) begin
              state    <= DRAIN;
              bready_q <= is_wr & resp_pend;
              rready_q <= ~is_wr & resp_pend;
            end else begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
            end
          end
        end

        DRAIN: begin
          // Late response is accepted and dropped; fields stay as reported
          if (!busy_after) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cl_sda_mstr.sv
module tb_cl_sda_mstr;

  localparam int unsigned T = 8;

  logic        aclk;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic [15:0] err_cnt;

  axi_bus_t axil ();

  cl_sda_mstr #(.TIMEOUT_CYCLES(T), .ERR_CNT_W(16)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .rsp_timeout (rsp_timeout),
    .m_axil      (axil),
    .err_cnt     (err_cnt)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
    logic [15:0] err;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Slave behaviour for the current transaction
  int unsigned c_aw_d, c_w_d, c_b_d, c_ar_d, c_r_d;
  logic [1:0]  c_resp;
  logic [31:0] c_rdata, c_addr, c_wdata;
  logic [3:0]  c_wstrb;
  logic [15:0] exp_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      rsp_ready = ($urandom_range(0, 9) < 7);
    end
  end

  // AXI-Lite responder with per-channel delays taken from c_*
  initial begin : slave
    int unsigned n_aw, n_w, n_ar, bcnt, rcnt;
    bit aw_done, w_done, b_owed, r_owed;
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r, pv_aw, pv_w, pv_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    n_aw = 0; n_w = 0; n_ar = 0; bcnt = 0; rcnt = 0;
    aw_done = 0; w_done = 0; b_owed = 0; r_owed = 0;
    axil.awready = 0; axil.wready = 0; axil.arready = 0;
    axil.bvalid = 0; axil.bresp = 0; axil.rvalid = 0; axil.rresp = 0; axil.rdata = 0;
    forever begin
      @(posedge aclk);
      hs_aw = axil.awvalid && axil.awready;
      hs_w  = axil.wvalid  && axil.wready;
      hs_ar = axil.arvalid && axil.arready;
      hs_b  = axil.bvalid  && axil.bready;
      hs_r  = axil.rvalid  && axil.rready;
      pv_aw = axil.awvalid && !axil.awready;
      pv_w  = axil.wvalid  && !axil.wready;
      pv_ar = axil.arvalid && !axil.arready;
      p_awaddr = axil.awaddr; p_wdata = axil.wdata; p_wstrb = axil.wstrb; p_araddr = axil.araddr;
      if (hs_aw) chk("awaddr", 64'(axil.awaddr), 64'(c_addr));
      if (hs_w) begin
        chk("wdata", 64'(axil.wdata), 64'(c_wdata));
        chk("wstrb", 64'(axil.wstrb), 64'(c_wstrb));
      end
      if (hs_ar) chk("araddr", 64'(axil.araddr), 64'(c_addr));
      #1;
      if (!aresetn) begin
        n_aw = 0; n_w = 0; n_ar = 0; bcnt = 0; rcnt = 0;
        aw_done = 0; w_done = 0; b_owed = 0; r_owed = 0;
        axil.awready = 0; axil.wready = 0; axil.arready = 0;
        axil.bvalid = 0; axil.rvalid = 0;
        continue;
      end
      if (pv_aw) chk("aw_hold", {31'd0, axil.awvalid, axil.awaddr}, {31'd0, 1'b1, p_awaddr});
      if (pv_w)  chk("w_hold", {27'd0, axil.wvalid, axil.wstrb, axil.wdata}, {27'd0, 1'b1, p_wstrb, p_wdata});
      if (pv_ar) chk("ar_hold", {31'd0, axil.arvalid, axil.araddr}, {31'd0, 1'b1, p_araddr});
      if (hs_aw) chk("aw_drop", 64'(axil.awvalid), 64'd0);
      if (hs_w)  chk("w_drop", 64'(axil.wvalid), 64'd0);
      if (hs_ar) chk("ar_drop", 64'(axil.arvalid), 64'd0);
      if (hs_aw) aw_done = 1;
      if (hs_w)  w_done = 1;
      if (aw_done && w_done) begin b_owed = 1; bcnt = 0; aw_done = 0; w_done = 0; end
      if (hs_ar) begin r_owed = 1; rcnt = 0; end
      if (hs_b) axil.bvalid = 0;
      if (hs_r) axil.rvalid = 0;
      if (axil.awvalid) begin n_aw++; axil.awready = (n_aw > c_aw_d); end
      else begin n_aw = 0; axil.awready = 0; end
      if (axil.wvalid) begin n_w++; axil.wready = (n_w > c_w_d); end
      else begin n_w = 0; axil.wready = 0; end
      if (axil.arvalid) begin n_ar++; axil.arready = (n_ar > c_ar_d); end
      else begin n_ar = 0; axil.arready = 0; end
      if (b_owed && !axil.bvalid) begin
        if (bcnt >= c_b_d) begin axil.bvalid = 1; axil.bresp = c_resp; b_owed = 0; end
        else bcnt++;
      end
      if (r_owed && !axil.rvalid) begin
        if (rcnt >= c_r_d) begin
          axil.rvalid = 1; axil.rresp = c_resp; axil.rdata = c_rdata; r_owed = 0;
        end else rcnt++;
      end
    end
  end

  // Completion monitor: pops the scoreboard on every rsp handshake
  initial begin : monitor
    int unsigned cyc, acc, lat;
    bit seen, axi_chk, axi_wr;
    exp_t e;
    cyc = 0; acc = 0; lat = 0; seen = 0; axi_chk = 0; axi_wr = 0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (!aresetn) begin seen = 0; axi_chk = 0; continue; end
      if (axi_chk) begin
        axi_chk = 0;
        if (axi_wr) chk("wr_valid_c1", {62'd0, axil.awvalid, axil.wvalid}, 64'd3);
        else        chk("rd_valid_c1", 64'(axil.arvalid), 64'd1);
      end
      if (cmd_valid && cmd_ready) begin
        acc = cyc; axi_chk = 1; axi_wr = cmd_wr;
      end
      if (rsp_valid) begin
        if (!seen) begin seen = 1; lat = cyc - acc; end
        if (rsp_ready) begin
          seen = 0;
          if (sb.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
          else begin
            e = sb.pop_front();
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
            chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
            chk("err_cnt", 64'(err_cnt), 64'(e.err));
            chk("rsp_latency", 64'(lat), 64'(e.lat));
          end
        end
      end
    end
  end

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(posedge aclk);
      #1;
    end
    if (!ok) chk("cmd_ready_wait", 64'd0, 64'd1);
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wd32,
                       input logic [3:0] strb);
    cmd_valid = 1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd32; cmd_wstrb = strb;
    @(posedge aclk);
    #1;
    cmd_valid = 0; cmd_wr = $urandom_range(0, 1);
    cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
  endtask

  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd32,
                        input logic [3:0] strb, input int unsigned awd, input int unsigned wdd,
                        input int unsigned bd, input int unsigned ard, input int unsigned rd,
                        input logic [1:0] resp, input logic [31:0] rdata);
    bit ok;
    int unsigned re;
    exp_t e;
    wait_idle(ok);
    if (!ok) return;
    c_aw_d = awd; c_w_d = wdd; c_b_d = bd; c_ar_d = ard; c_r_d = rd;
    c_resp = resp; c_rdata = rdata; c_addr = addr; c_wdata = wd32; c_wstrb = strb;
    // Edge (counted from acceptance) at which the B/R response is taken
    if (wr) re = ((awd > wdd) ? awd : wdd) + 2 + bd;
    else    re = ard + 2 + rd;
    e.tmo   = (re > T);
    e.resp  = e.tmo ? 2'b10 : resp;
    e.rdata = (e.tmo || wr) ? 32'd0 : rdata;
    e.lat   = e.tmo ? T + 1 : re + 1;
    if ((e.tmo || e.resp != 2'b00) && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
    e.err   = exp_err;
    sb.push_back(e);
    issue(wr, addr, wd32, strb);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    logic [1:0] rs;
    int unsigned mx;
    aresetn = 0; cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    exp_err = 0;
    c_aw_d = 0; c_w_d = 0; c_b_d = 0; c_ar_d = 0; c_r_d = 0;
    c_resp = 0; c_rdata = 0; c_addr = 0; c_wdata = 0; c_wstrb = 0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_axi", {59'd0, axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready}, 64'd0);
    chk("rst_rsp", {28'd0, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    #3 aresetn = 1;
    #1 chk("cmd_ready_at_release", 64'(cmd_ready), 64'd0);
    @(posedge aclk);
    #1 chk("cmd_ready_after_release", 64'(cmd_ready), 64'd1);

    do_txn(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'd0);
    do_txn(1, 32'h0000_0014, 32'hCAFE_0001, 4'h3, 0, 5, 0, 0, 0, 2'b00, 32'd0);
    do_txn(0, 32'h0000_0020, 32'd0, 4'h0, 0, 0, 0, 0, 0, 2'b10, 32'h1234_5678);
    do_txn(0, 32'h0000_0024, 32'd0, 4'h0, 0, 0, 0, 20, 0, 2'b00, 32'hAAAA_5555);
    do_txn(0, 32'h0000_0028, 32'd0, 4'h0, 0, 0, 0, 0, 6, 2'b00, 32'h0BAD_F00D);
    do_txn(0, 32'h0000_002C, 32'd0, 4'h0, 0, 0, 0, 0, 7, 2'b00, 32'h5A5A_A5A5);
    do_txn(1, 32'h0000_0030, 32'h0102_0304, 4'h9, 3, 3, 3, 0, 0, 2'b11, 32'd0);
    do_txn(1, 32'h0000_0034, 32'h0506_0708, 4'h6, 3, 1, 4, 0, 0, 2'b00, 32'd0);

    for (int i = 0; i < 40; i++) begin
      mx = ($urandom_range(0, 5) == 0) ? 12 : 3;
      rs = 2'($urandom_range(0, 3));
      if (rs == 2'b01) rs = 2'b00;
      do_txn(1'($urandom_range(0, 1)), {$urandom_range(0, 255), 2'b00} + 32'h1000,
             $urandom, 4'($urandom), $urandom_range(0, mx), $urandom_range(0, mx),
             $urandom_range(0, mx), $urandom_range(0, mx), $urandom_range(0, mx), rs, $urandom);
    end

    // Reset while a write sits in WR_RESP waiting for a slow B
    wait_idle(ok);
    c_aw_d = 0; c_w_d = 0; c_b_d = 40; c_resp = 2'b00;
    c_addr = 32'h0000_0040; c_wdata = 32'h7777_8888; c_wstrb = 4'hF;
    issue(1, 32'h0000_0040, 32'h7777_8888, 4'hF);
    repeat (3) @(posedge aclk);
    #3 aresetn = 0;
    #1;
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("midrst_axi", {59'd0, axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready}, 64'd0);
    chk("midrst_rsp", {28'd0, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, 64'd0);
    chk("midrst_err_cnt", 64'(err_cnt), 64'd0);
    sb.delete();
    exp_err = 0;
    repeat (2) @(posedge aclk);
    #4 aresetn = 1;
    @(posedge aclk);
    #1 chk("cmd_ready_after_midrst", 64'(cmd_ready), 64'd1);
    do_txn(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'd0);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge aclk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    wait_idle(ok);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
